// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write-side companion to the byte-wide instruction memory. Program words
// arrive over a valid/ready stream. Each word is written into IMEM as four
// consecutive byte writes in little-endian order: byte0 goes to the word
// address and byte3 goes to the word address + 3. The processor core is held
// in reset while a load is in progress. It is released when the word marked
// "last" has been written, or when the program runs off the top of IMEM.
//
// Parameters
//   ADDR_W     IMEM byte-address width
//   BASE_ADDR  byte address of the first word (multiple of 4)
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         begin a load session (honoured only in IDLE/DONE)
//   word_valid    word_data/word_last are valid
//   word_data     32-bit program word
//   word_last     marks the final word of the program
//   word_ready    loader accepts a word this cycle (RECV only)
//   mem_we        IMEM byte write enable
//   mem_addr      IMEM byte address
//   mem_wdata     IMEM byte data
//   core_hold     1 = hold the processor in reset (RECV/WRITE)
//   done          load finished (level)
//   overflow_err  program exceeded IMEM (sticky until the next start)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              overflow_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_WORD = ADDR_W'((1 << ADDR_W) - 4);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_WRD = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        byte_idx;
  logic [23:0]       byte_buf;
  logic              last_buf;

  // Every output is a register. Each output is updated on the same edge
  // where the state changes, so the outputs always match the current state.
  //
  // byte0 of an accepted word goes out on the accept edge. The remaining
  // three bytes are kept in byte_buf and shifted down one byte per WRITE
  // cycle. byte_idx records which byte is currently on mem_wdata. Because
  // word_addr is always 4-byte aligned, mem_addr can simply step by one
  // within a word and never carries out of the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      word_addr    <= BASE;
      byte_idx     <= 2'd0;
      byte_buf     <= 24'h0;
      last_buf     <= 1'b0;
      word_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 8'h00;
      core_hold    <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      case (state)
        // IDLE and DONE both wait for start. start opens a new session at
        // BASE_ADDR and clears any status left over from the previous one.
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_RECV;
            word_addr    <= BASE;
            word_ready   <= 1'b1;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            overflow_err <= 1'b0;
          end
        end

        // Wait for the producer. On a handshake, latch the word and
        // present its first byte immediately.
        S_RECV: begin
          if (word_valid) begin
            state      <= S_WRITE;
            word_ready <= 1'b0;
            byte_idx   <= 2'd0;
            byte_buf   <= word_data[31:8];
            last_buf   <= word_last;
            mem_we     <= 1'b1;
            mem_addr   <= word_addr;
            mem_wdata  <= word_data[7:0];
          end
        end

        // Four write cycles per word. After the fourth cycle, decide where
        // to go next. The last flag takes priority over the top-of-memory
        // check, so a program that ends exactly on the top word is not
        // flagged as an overflow.
        S_WRITE: begin
          if (byte_idx != 2'd3) begin
            byte_idx  <= byte_idx + 2'd1;
            mem_addr  <= mem_addr + ADDR_ONE;
            mem_wdata <= byte_buf[7:0];
            byte_buf  <= {8'h00, byte_buf[23:8]};
          end else begin
            mem_we    <= 1'b0;
            word_addr <= word_addr + ADDR_WRD;
            if (last_buf) begin
              state     <= S_DONE;
              core_hold <= 1'b0;
              done      <= 1'b1;
            end else if (word_addr == TOP_WORD) begin
              state        <= S_DONE;
              core_hold    <= 1'b0;
              done         <= 1'b1;
              overflow_err <= 1'b1;
            end else begin
              state      <= S_RECV;
              word_ready <= 1'b1;
            end
          end
        end

        default: begin
          state      <= S_IDLE;
          word_ready <= 1'b0;
          mem_we     <= 1'b0;
          core_hold  <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Testbench for imem_loader. It instantiates the design twice:
//   - dut_main uses the default 1 KiB configuration.
//   - dut_small uses ADDR_W=4 (16 bytes) so overflow is reachable.
// One stimulus bus drives both instances. sel gates which instance sees the
// active inputs; the other instance sees zeros.
//
// Each time a word is accepted, its four expected byte writes are pushed onto
// the per-instance queue. A negedge monitor pops one entry per observed
// mem_we cycle and compares it with the actual address and data.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        start_d;
  logic        valid_d;
  logic        last_d;
  logic [31:0] data_d;

  logic        m_ready, m_we, m_hold, m_done, m_ovf;
  logic [9:0]  m_addr;
  logic [7:0]  m_wdata;
  logic        s_ready, s_we, s_hold, s_done, s_ovf;
  logic [3:0]  s_addr;
  logic [7:0]  s_wdata;

  int check_count = 0;
  int error_count = 0;
  int main_ready_cnt = 0;
  int main_we_cnt = 0;
  int small_we_cnt = 0;
  int model_addr_main = 0;
  int model_addr_small = 0;

  // Each entry is {16-bit byte address, 8-bit data}.
  logic [23:0] q_main[$];
  logic [23:0] q_small[$];

  imem_loader dut_main (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start_d & ~sel),
    .word_valid   (valid_d & ~sel),
    .word_data    (data_d),
    .word_last    (last_d),
    .word_ready   (m_ready),
    .mem_we       (m_we),
    .mem_addr     (m_addr),
    .mem_wdata    (m_wdata),
    .core_hold    (m_hold),
    .done         (m_done),
    .overflow_err (m_ovf)
  );

  imem_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut_small (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start_d & sel),
    .word_valid   (valid_d & sel),
    .word_data    (data_d),
    .word_last    (last_d),
    .word_ready   (s_ready),
    .mem_we       (s_we),
    .mem_addr     (s_addr),
    .mem_wdata    (s_wdata),
    .core_hold    (s_hold),
    .done         (s_done),
    .overflow_err (s_ovf)
  );

  // Count one comparison; on a mismatch, report it and count an error.
  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic cur_ready();
    return sel ? s_ready : m_ready;
  endfunction

  function automatic logic cur_done();
    return sel ? s_done : m_done;
  endfunction

  // Monitor for dut_main: score every byte write and count ready/write cycles.
  always @(negedge clk) begin : mon_main
    logic [23:0] e;
    if (rst_n && m_we) begin
      if (q_main.size() == 0) begin
        check_output("main_stray_write", 32'(m_addr), 32'hFFFF_FFFF);
      end else begin
        e = q_main.pop_front();
        check_output("main_write", {14'h0, m_addr, m_wdata}, {8'h0, e});
      end
      check_output("main_hold_in_write", 32'(m_hold), 32'd1);
      main_we_cnt++;
    end
    if (m_ready) main_ready_cnt++;
  end

  // Monitor for dut_small: score every byte write and count write cycles.
  always @(negedge clk) begin : mon_small
    logic [23:0] e;
    if (rst_n && s_we) begin
      if (q_small.size() == 0) begin
        check_output("small_stray_write", 32'(s_addr), 32'hFFFF_FFFF);
      end else begin
        e = q_small.pop_front();
        check_output("small_write", {20'h0, s_addr, s_wdata}, {8'h0, e});
      end
      small_we_cnt++;
    end
  end

  // Pulse start for one cycle and rewind the bench's address model to base.
  task automatic pulse_start();
    start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    if (sel) model_addr_small = 0;
    else     model_addr_main  = 0;
  endtask

  // Offer one word for up to max_wait cycles. If it is accepted, push the
  // four little-endian byte writes it should produce onto the queue.
  task automatic apply_stimulus(input logic [31:0] d, input logic l, input int max_wait,
                                output logic acc);
    logic [31:0] w;
    w = d;
    acc = 1'b0;
    valid_d = 1'b1;
    data_d  = d;
    last_d  = l;
    for (int i = 0; i < max_wait; i++) begin
      if (cur_ready()) begin
        acc = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (sel) q_small.push_back({16'((model_addr_small + b) & 32'hF),  w[8*b +: 8]});
          else     q_main.push_back ({16'((model_addr_main  + b) & 32'h3FF), w[8*b +: 8]});
        end
        if (sel) model_addr_small = (model_addr_small + 4) & 32'hF;
        else     model_addr_main  = (model_addr_main  + 4) & 32'h3FF;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    valid_d = 1'b0;
    last_d  = 1'b0;
  endtask

  // Wait, with a cycle budget, for done on the selected instance.
  task automatic wait_done(input string tag, input int max_wait);
    for (int i = 0; i < max_wait; i++) begin
      if (cur_done()) break;
      @(posedge clk); #1;
    end
    check_output(tag, 32'(cur_done()), 32'd1);
  endtask

  initial begin : stim
    logic acc;
    int   snap_ready;
    int   snap_we;

    rst_n = 1'b0; sel = 1'b0; start_d = 1'b0;
    valid_d = 1'b0; last_d = 1'b0; data_d = 32'h0;
    repeat (2) @(posedge clk); #1;

    // Reset values.
    check_output("rst_ready", 32'(m_ready), 32'd0);
    check_output("rst_we",    32'(m_we),    32'd0);
    check_output("rst_hold",  32'(m_hold),  32'd0);
    check_output("rst_done",  32'(m_done),  32'd0);
    check_output("rst_ovf",   32'(m_ovf),   32'd0);
    check_output("rst_addr",  32'(m_addr),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: reset asserted mid-WRITE, after the idx=1 byte.
    pulse_start();
    apply_stimulus(32'hCAFEF00D, 1'b1, 10, acc);
    check_output("t1_accept", 32'(acc), 32'd1);
    @(posedge clk); #7;
    rst_n = 1'b0;
    #1;
    check_output("t1_we",   32'(m_we),   32'd0);
    check_output("t1_hold", 32'(m_hold), 32'd0);
    check_output("t1_done", 32'(m_done), 32'd0);
    q_main.delete();
    @(posedge clk); #1;
    check_output("t1_we_next", 32'(m_we), 32'd0);
    rst_n = 1'b1;
    snap_we = main_we_cnt;
    valid_d = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_output("t1_idle_ready", 32'(m_ready), 32'd0);
      check_output("t1_idle_hold",  32'(m_hold),  32'd0);
    end
    valid_d = 1'b0;
    check_output("t1_idle_no_we", 32'(main_we_cnt - snap_we), 32'd0);

    // Test 2: one word with last=1.
    pulse_start();
    check_output("t2_hold_recv", 32'(m_hold), 32'd1);
    apply_stimulus(32'hDEADBEEF, 1'b1, 10, acc);
    check_output("t2_accept", 32'(acc), 32'd1);
    wait_done("t2_done", 20);
    check_output("t2_hold", 32'(m_hold), 32'd0);
    check_output("t2_ovf",  32'(m_ovf),  32'd0);
    check_output("t2_q_empty", 32'(q_main.size()), 32'd0);

    // Test 3: three back-to-back words; word_ready high one cycle per word.
    snap_ready = main_ready_cnt;
    snap_we    = main_we_cnt;
    pulse_start();
    apply_stimulus(32'h11111111, 1'b0, 10, acc);
    check_output("t3_acc0", 32'(acc), 32'd1);
    apply_stimulus(32'h22222222, 1'b0, 10, acc);
    check_output("t3_acc1", 32'(acc), 32'd1);
    apply_stimulus(32'h33333333, 1'b1, 10, acc);
    check_output("t3_acc2", 32'(acc), 32'd1);
    wait_done("t3_done", 20);
    check_output("t3_ready_cycles", 32'(main_ready_cnt - snap_ready), 32'd3);
    check_output("t3_write_cycles", 32'(main_we_cnt - snap_we), 32'd12);

    // Test 4: producer idle for 7 cycles in RECV, then a word.
    pulse_start();
    snap_we = main_we_cnt;
    repeat (7) begin
      @(posedge clk); #1;
      check_output("t4_hold", 32'(m_hold), 32'd1);
    end
    check_output("t4_no_we", 32'(main_we_cnt - snap_we), 32'd0);
    check_output("t4_ready", 32'(m_ready), 32'd1);
    apply_stimulus(32'h0BADC0DE, 1'b1, 10, acc);
    check_output("t4_accept", 32'(acc), 32'd1);
    wait_done("t4_done", 20);

    // Test 5: the 16-byte instance overflows on the fifth word.
    sel = 1'b1;
    snap_we = small_we_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(32'hA0A1A2A3 + 32'(i) * 32'h04040404, 1'b0, 10, acc);
      check_output("t5_accept", 32'(acc), 32'd1);
    end
    apply_stimulus(32'hFFEEDDCC, 1'b0, 15, acc);
    check_output("t5_fifth_rejected", 32'(acc), 32'd0);
    wait_done("t5_done", 5);
    check_output("t5_ovf",  32'(s_ovf),  32'd1);
    check_output("t5_hold", 32'(s_hold), 32'd0);
    check_output("t5_bytes", 32'(small_we_cnt - snap_we), 32'd16);

    // Test 6: start in DONE clears status and restarts at base.
    pulse_start();
    check_output("t6_done_clr", 32'(s_done),  32'd0);
    check_output("t6_ovf_clr",  32'(s_ovf),   32'd0);
    check_output("t6_ready",    32'(s_ready), 32'd1);
    apply_stimulus(32'h5A6B7C8D, 1'b1, 10, acc);
    check_output("t6_accept", 32'(acc), 32'd1);
    wait_done("t6_done", 20);
    check_output("t6_ovf", 32'(s_ovf), 32'd0);

    // Boundary: last=1 on the top word finishes without overflow.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(32'h10203040 + 32'(i), (i == 3), 10, acc);
      check_output("top_accept", 32'(acc), 32'd1);
    end
    wait_done("top_done", 20);
    check_output("top_ovf", 32'(s_ovf), 32'd0);

    @(posedge clk); #1;
    check_output("main_q_empty",  32'(q_main.size()),  32'd0);
    check_output("small_q_empty", 32'(q_small.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
